// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared types and sizing helper for the async GP FIFO write side
//
// Purpose: state encoding for the write-side packer and the FIFO word-width
// function the parent uses to size its FIFO instance.
`timescale 1ns/1ps
package async_fifo_pkg;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PARTIAL = 1'b1
    } pk_state_t;

    // One FIFO word: {last, keep[ratio-1:0], data[ratio*in_width-1:0]}
    function automatic int pk_word_w(input int in_width, input int ratio);
        return in_width * ratio + ratio + 1;
    endfunction

endpackage

// File: rtl/async_fifo_wr_packer.sv
// rtl/async_fifo_wr_packer.sv - packs narrow beats into wide FIFO words on the write clock
//
// Purpose: accepts a valid/ready beat stream, packs RATIO beats (lane 0 at the
// LSBs) into one FIFO word with a lane-keep mask and a last flag, and pushes it
// into the parent's async FIFO through a single holding register.
// Ports:
//   clk_wr, arst_wr   write clock, asynchronous active-high reset
//   in_valid_i        beat valid;  in_ready_o beat accepted when valid&ready
//   in_data_i         beat data;   in_last_i  beat closes a packet
//   flush_i           pulse: close the partial word now
//   fifo_wr_en_o      FIFO push strobe
//   fifo_wr_data_o    {last, keep, data}, zero when nothing is held
//   fifo_full_i       FIFO wr_full
//   pkt_cnt_o         count of pushed last-flagged words, wraps
`timescale 1ns/1ps
module async_fifo_wr_packer
    import async_fifo_pkg::*;
#(
    parameter  int IN_WIDTH = 8,
    parameter  int RATIO    = 4,
    localparam int FIFO_W   = pk_word_w(IN_WIDTH, RATIO)
) (
    input  logic                clk_wr,
    input  logic                arst_wr,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IN_WIDTH-1:0] in_data_i,
    input  logic                in_last_i,
    input  logic                flush_i,
    output logic                fifo_wr_en_o,
    output logic [FIFO_W-1:0]   fifo_wr_data_o,
    input  logic                fifo_full_i,
    output logic [15:0]         pkt_cnt_o
);

    localparam int DATA_W = RATIO * IN_WIDTH;
    localparam int LANE_W = $clog2(RATIO);

    pk_state_t           state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [RATIO-1:0]    keep_q, keep_d;
    logic                out_vld_q, out_vld_d;
    logic [FIFO_W-1:0]   out_word_q, out_word_d;
    logic                flush_pend_q, flush_pend_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;

    logic                in_ready;
    logic                accept;
    logic                push;
    logic                close;
    logic [DATA_W-1:0]   word_acc;
    logic [RATIO-1:0]    word_keep;

    // The holding slot can take a new word if it is empty or drains this cycle.
    assign in_ready = ~out_vld_q | ~fifo_full_i;
    assign accept   = in_valid_i & in_ready;
    assign push     = out_vld_q & ~fifo_full_i;

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        acc_d        = acc_q;
        keep_d       = keep_q;
        out_vld_d    = out_vld_q;
        out_word_d   = out_word_q;
        flush_pend_d = flush_pend_q;
        pkt_cnt_d    = pkt_cnt_q;

        // Accumulator as it looks including this cycle's beat, if any.
        word_acc  = acc_q;
        word_keep = keep_q;
        if (accept) begin
            word_acc[lane_q*IN_WIDTH +: IN_WIDTH] = in_data_i;
            word_keep[lane_q]                     = 1'b1;
        end

        // A flush (live or remembered) closes a partial word, or the word that
        // this cycle's accepted beat just started; it needs a free slot.
        close = (accept & ((lane_q == LANE_W'(RATIO - 1)) | in_last_i))
              | (in_ready & (flush_i | flush_pend_q) & ((state_q == ST_PARTIAL) | accept));

        if (push) begin
            out_vld_d = 1'b0;
            if (out_word_q[FIFO_W-1]) begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
        end

        if (close) begin
            out_word_d   = {in_last_i & accept, word_keep, word_acc};
            out_vld_d    = 1'b1;
            acc_d        = '0;
            keep_d       = '0;
            lane_d       = '0;
            state_d      = ST_EMPTY;
            flush_pend_d = 1'b0;
        end else if (accept) begin
            acc_d   = word_acc;
            keep_d  = word_keep;
            lane_d  = lane_q + LANE_W'(1);
            state_d = ST_PARTIAL;
        end else if (flush_i & ~in_ready & (state_q == ST_PARTIAL)) begin
            // Slot is blocked by a full FIFO; close as soon as it frees.
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_wr or posedge arst_wr) begin
        if (arst_wr) begin
            state_q      <= ST_EMPTY;
            lane_q       <= '0;
            acc_q        <= '0;
            keep_q       <= '0;
            out_vld_q    <= 1'b0;
            out_word_q   <= '0;
            flush_pend_q <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            acc_q        <= acc_d;
            keep_q       <= keep_d;
            out_vld_q    <= out_vld_d;
            out_word_q   <= out_word_d;
            flush_pend_q <= flush_pend_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign in_ready_o     = in_ready;
    assign fifo_wr_en_o   = push;
    assign fifo_wr_data_o = out_vld_q ? out_word_q : '0;
    assign pkt_cnt_o      = pkt_cnt_q;

`ifndef NO_ASSERTIONS
    if (RATIO < 2) begin : g_bad_ratio
        $error("async_fifo_wr_packer: RATIO must be at least 2");
    end

    a_no_push_full: assert property (@(posedge clk_wr) disable iff (arst_wr)
        !(fifo_wr_en_o && fifo_full_i));

    a_hold_stable: assert property (@(posedge clk_wr) disable iff (arst_wr)
        (out_vld_q && fifo_full_i) |=> $stable(out_word_q));
`endif

endmodule
